fft_frame_sink: RTL and testbench
=================================

FFT_FRAME_SINK -- requirements
Module: fft_frame_sink

Interface
REQ-001 Parameter N, default 256, meaning complex samples per frame (power of two).
REQ-002 Parameter WIDTHa, default 16, meaning bits per real/imag sample (fixed-point, passed through unchanged).
REQ-003 Parameter BITREV, default 0, meaning 1 = read buffer in bit-reversed address order, 0 = natural order.
REQ-004 clk  input  1  single clock, all logic rising-edge.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 vld_out  input  1  frame-start strobe from FFT, one cycle wide.
REQ-007 y_r  input  WIDTHa  real sample from FFT.
REQ-008 y_i  input  WIDTHa  imaginary sample from FFT.
REQ-009 m_valid  output  1  readout data valid.
REQ-010 m_ready  input  1  downstream accepts readout word.
REQ-011 m_r  output  WIDTHa  readout real sample.
REQ-012 m_i  output  WIDTHa  readout imaginary sample.
REQ-013 m_idx  output  log2(N)  output-order index of current word (0..N-1).
REQ-014 m_last  output  1  high with word m_idx = N-1.
REQ-015 busy  output  1  high in CAPTURE or DRAIN.
REQ-016 overrun  output  1  sticky, strobe arrived while busy.

Function
REQ-017 States IDLE, CAPTURE, DRAIN; one N-entry x 2*WIDTHa buffer.
REQ-018 IDLE: vld_out=1 -> CAPTURE, write counter = 0; no sample taken in the strobe cycle.
REQ-019 CAPTURE: on each of the N cycles after the strobe, store {y_r,y_i} at buffer[wcnt], wcnt++; no input gating, one sample per cycle.
REQ-020 CAPTURE -> DRAIN on the cycle wcnt = N-1 is written; strobe at cycle 0 -> samples on cycles 1..N -> m_valid first high on cycle N+1.
REQ-021 DRAIN: word k read from buffer[bitrev(k)] when BITREV=1, buffer[k] otherwise; m_idx = k.
REQ-022 m_r, m_i, m_idx, m_last registered; load next word when m_valid=0 or (m_valid & m_ready).
REQ-023 m_valid held with stable m_r/m_i/m_idx/m_last until m_ready=1; m_ready with m_valid=0 ignored.
REQ-024 Sustained m_ready=1 -> one word per cycle, N consecutive m_valid cycles.
REQ-025 Handshake on m_last -> m_valid=0 next cycle, state IDLE.
REQ-026 vld_out in same cycle as the m_last handshake -> accepted as new frame, CAPTURE next cycle.
REQ-027 vld_out in CAPTURE or DRAIN (other than REQ-026) -> ignored, frame state undisturbed, overrun=1.
REQ-028 overrun cleared only by rst.
REQ-029 busy = 1 from the cycle after an accepted strobe through the cycle of the m_last handshake.
REQ-030 Counters wrap-free: wcnt and rcnt never exceed N-1; index width exactly log2(N).

Reset
REQ-031 rst=1 -> state IDLE, counters 0, m_valid=0, m_last=0, m_idx=0, m_r=0, m_i=0, busy=0, overrun=0 on the next edge.
REQ-032 Buffer contents not reset; rst mid-CAPTURE or mid-DRAIN abandons the frame, no partial readout.
REQ-033 vld_out during rst ignored; first strobe after rst deasserts accepted normally.

Verification
REQ-034 Ramp: strobe, y_r=k, y_i=-k for k=0..255, m_ready=1, BITREV=0 -> m_valid on cycle 257, m_r=0..255 in order, m_last with m_r=255, 256 valid cycles.
REQ-035 Bit-reverse: same ramp, BITREV=1 -> m_idx=1 carries m_r=128, m_idx=2 carries m_r=64, m_idx=255 carries m_r=255.
REQ-036 Backpressure: m_ready toggled 1/0 each cycle -> all 256 words delivered once, in order, data stable while m_ready=0, drain takes 511-512 cycles.
REQ-037 Overrun: second strobe at capture cycle 100 -> overrun=1 and stays 1, readout identical to REQ-034; second strobe in cycle of m_last handshake -> overrun stays 0, second frame captured.
REQ-038 Reset mid-operation: rst at capture cycle 50 -> all outputs 0 next cycle, no m_valid; new strobe -> full correct frame.
REQ-039 Back-to-back: two frames, m_ready=1, second strobe on the m_last handshake cycle -> both frames complete, overrun=0.

Source files
------------

// File: rtl/fft_frame_sink_if.sv
// Handshake bundle for fft_frame_sink: FFT sample stream in, buffered readout out.
interface fft_frame_sink_if #(
   parameter int N      = 256,
   parameter int WIDTHa = 16
);
   logic                   vld_out;
   logic [WIDTHa-1:0]      y_r;
   logic [WIDTHa-1:0]      y_i;
   logic                   m_valid;
   logic                   m_ready;
   logic [WIDTHa-1:0]      m_r;
   logic [WIDTHa-1:0]      m_i;
   logic [$clog2(N)-1:0]   m_idx;
   logic                   m_last;

   modport master (
      output vld_out, y_r, y_i, m_ready,
      input  m_valid, m_r, m_i, m_idx, m_last
   );

   modport slave (
      input  vld_out, y_r, y_i, m_ready,
      output m_valid, m_r, m_i, m_idx, m_last
   );
endinterface

// File: rtl/fft_frame_sink.sv
// Captures one N-sample FFT frame after a start strobe, then drains it through a
// valid/ready port in natural or bit-reversed order.
module fft_frame_sink #(
   parameter int N      = 256,
   parameter int WIDTHa = 16,
   parameter bit BITREV = 1'b0
) (
   input  logic             clk,
   input  logic             rst,
   fft_frame_sink_if.slave  bus,
   output logic             busy,
   output logic             overrun
);
   localparam int            IW   = $clog2(N);
   localparam logic [IW-1:0] LAST = IW'(N - 1);

   typedef enum logic [1:0] {IDLE, CAPTURE, DRAIN} state_t;

   state_t              state;
   state_t              state_next;
   logic [IW-1:0]       wcnt;
   logic [2*WIDTHa-1:0] mem [N];

   logic                wr_en;
   logic                load;
   logic                done;
   logic                accept;
   logic                ovr_set;
   logic                hs;
   logic [IW-1:0]       load_idx;
   logic [IW-1:0]       rd_addr;

   function automatic logic [IW-1:0] bitrev(input logic [IW-1:0] a);
      logic [IW-1:0] r;
      r = '0;
      for (int unsigned b = 0; b < IW; b++) begin
         r[b] = a[IW-1-b];
      end
      return r;
   endfunction

   assign hs   = bus.m_valid & bus.m_ready;
   assign busy = (state != IDLE);

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Word 0 is loaded on the same edge that writes the last sample, so the
   // first valid word appears the cycle after capture ends.
   always_comb begin
      state_next = state;
      wr_en      = 1'b0;
      load       = 1'b0;
      done       = 1'b0;
      accept     = 1'b0;
      ovr_set    = 1'b0;
      load_idx   = bus.m_idx + IW'(1);
      case (state)
         IDLE: begin
            if (bus.vld_out) begin
               accept     = 1'b1;
               state_next = CAPTURE;
            end
         end
         CAPTURE: begin
            wr_en   = 1'b1;
            ovr_set = bus.vld_out;
            if (wcnt == LAST) begin
               state_next = DRAIN;
               load       = 1'b1;
               load_idx   = '0;
            end
         end
         DRAIN: begin
            if (hs && bus.m_last) begin
               done = 1'b1;
               if (bus.vld_out) begin
                  accept     = 1'b1;
                  state_next = CAPTURE;
               end else begin
                  state_next = IDLE;
               end
            end else begin
               ovr_set = bus.vld_out;
               load    = hs;
            end
         end
         default: state_next = IDLE;
      endcase
      rd_addr = BITREV ? bitrev(load_idx) : load_idx;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wcnt    <= '0;
         overrun <= 1'b0;
      end else begin
         if (accept) begin
            wcnt <= '0;
         end else if (wr_en) begin
            wcnt <= wcnt + IW'(1);
         end
         if (ovr_set) begin
            overrun <= 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst && wr_en) begin
         mem[wcnt] <= {bus.y_r, bus.y_i};
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         bus.m_valid <= 1'b0;
         bus.m_last  <= 1'b0;
         bus.m_idx   <= '0;
         bus.m_r     <= '0;
         bus.m_i     <= '0;
      end else if (load) begin
         bus.m_valid            <= 1'b1;
         bus.m_idx              <= load_idx;
         bus.m_last             <= (load_idx == LAST);
         {bus.m_r, bus.m_i}     <= mem[rd_addr];
      end else if (done) begin
         bus.m_valid <= 1'b0;
         bus.m_last  <= 1'b0;
      end
   end
endmodule

// File: tb/tb_fft_frame_sink.sv
// Drives two sinks (natural and bit-reversed order) with the same stimulus and
// checks both every cycle against a frame-level reference model.
module tb_fft_frame_sink;
   localparam int N   = 256;
   localparam int W   = 16;
   localparam int LOG = $clog2(N);

   logic clk = 1'b0;
   logic rst;
   logic vld;
   logic rdy;
   logic [W-1:0] yr;
   logic [W-1:0] yi;
   logic busy0, busy1, ovr0, ovr1;

   fft_frame_sink_if #(.N(N), .WIDTHa(W)) bus0 ();
   fft_frame_sink_if #(.N(N), .WIDTHa(W)) bus1 ();

   assign bus0.vld_out = vld;
   assign bus0.y_r     = yr;
   assign bus0.y_i     = yi;
   assign bus0.m_ready = rdy;
   assign bus1.vld_out = vld;
   assign bus1.y_r     = yr;
   assign bus1.y_i     = yi;
   assign bus1.m_ready = rdy;

   fft_frame_sink #(.N(N), .WIDTHa(W), .BITREV(1'b0)) dut0 (
      .clk(clk), .rst(rst), .bus(bus0), .busy(busy0), .overrun(ovr0));
   fft_frame_sink #(.N(N), .WIDTHa(W), .BITREV(1'b1)) dut1 (
      .clk(clk), .rst(rst), .bus(bus1), .busy(busy1), .overrun(ovr1));

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;
   bit chk_en   = 1'b0;
   int rmode    = 0;

   task automatic chk(input string nm, input int d, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s dut%0d got %0h exp %0h @%0t", nm, d, got, exp, $time);
      end
   endtask

   function automatic int brev(input int k);
      int r;
      r = 0;
      for (int b = 0; b < LOG; b++) r = r * 2 + ((k >> b) & 1);
      return r;
   endfunction

   // Reference model: mst 0 = idle, 1 = collecting samples, 2 = delivering words
   int          mst  = 0;
   int          mcap = 0;
   int          mk   = 0;
   bit          mvalid = 1'b0;
   bit          movr   = 1'b0;
   logic [31:0] mframe [N];

   always @(posedge clk) begin
      if (rst) begin
         mst = 0; mvalid = 1'b0; movr = 1'b0; mk = 0; mcap = 0;
      end else begin
         case (mst)
            0: if (vld) begin mst = 1; mcap = 0; end
            1: begin
               mframe[mcap] = {yr, yi};
               mcap++;
               if (vld) movr = 1'b1;
               if (mcap == N) begin mst = 2; mk = 0; mvalid = 1'b1; end
            end
            default: begin
               if (rdy && mk == N - 1) begin
                  mvalid = 1'b0;
                  if (vld) begin mst = 1; mcap = 0; end
                  else mst = 0;
               end else begin
                  if (vld) movr = 1'b1;
                  if (rdy) mk++;
               end
            end
         endcase
      end
   end

   // Per-cycle comparison of both sinks against the model
   initial forever begin
      @(negedge clk);
      if (chk_en) begin
         logic [31:0] e0, e1;
         chk("valid", 0, bus0.m_valid, mvalid);
         chk("valid", 1, bus1.m_valid, mvalid);
         chk("busy", 0, busy0, mst != 0);
         chk("busy", 1, busy1, mst != 0);
         chk("overrun", 0, ovr0, movr);
         chk("overrun", 1, ovr1, movr);
         if (mvalid) begin
            e0 = mframe[mk];
            e1 = mframe[brev(mk)];
            chk("idx", 0, bus0.m_idx, mk);
            chk("idx", 1, bus1.m_idx, mk);
            chk("re", 0, bus0.m_r, e0[31:16]);
            chk("im", 0, bus0.m_i, e0[15:0]);
            chk("re", 1, bus1.m_r, e1[31:16]);
            chk("im", 1, bus1.m_i, e1[15:0]);
            chk("last", 0, bus0.m_last, mk == N - 1);
            chk("last", 1, bus1.m_last, mk == N - 1);
         end
      end
   end

   // Readout ready pattern: 0 always, 1 toggle, 2 random
   initial begin
      rdy = 1'b1;
      forever begin
         @(negedge clk);
         case (rmode)
            0:       rdy = 1'b1;
            1:       rdy = ~rdy;
            default: rdy = ($urandom % 3) != 0;
         endcase
      end
   end

   int          vcnt0 = 0;
   logic [W-1:0] lastr0;
   logic [W-1:0] rec1 [N];
   initial forever begin
      @(negedge clk);
      if (bus0.m_valid) vcnt0++;
      if (bus0.m_valid && bus0.m_last) lastr0 = bus0.m_r;
      if (bus1.m_valid) rec1[bus1.m_idx] = bus1.m_r;
   end

   task automatic wait_idle();
      for (int i = 0; i < 3000; i++) begin
         @(negedge clk);
         if (mst == 0) return;
      end
      chk("idle_timeout", 0, 0, 1);
   endtask

   // pat 0 = ramp (y_r=k, y_i=-k), 1 = random; extra_at/rst_at are cycles after the strobe
   task automatic send_frame(input int pat, input int extra_at, input int rst_at,
                             input bit wait_hs, output int fv);
      bit found;
      fv = -1;
      if (wait_hs) begin
         found = 1'b0;
         for (int i = 0; i < 3000 && !found; i++) begin
            @(negedge clk);
            if (mvalid && mk == N - 1) found = 1'b1;
         end
         if (!found) chk("hs_timeout", 0, 0, 1);
      end else begin
         @(negedge clk);
      end
      vld = 1'b1;
      for (int c = 1; c <= N; c++) begin
         @(negedge clk);
         vld = (c == extra_at);
         yr  = (pat == 0) ? W'(c - 1) : W'($urandom);
         yi  = (pat == 0) ? W'(-(c - 1)) : W'($urandom);
         if (c == rst_at) begin
            rst = 1'b1;
            @(negedge clk);
            rst = 1'b0;
            vld = 1'b0;
            chk("rst_valid", 0, bus0.m_valid, 0);
            chk("rst_busy", 0, busy0, 0);
            chk("rst_idx", 1, bus1.m_idx, 0);
            chk("rst_re", 0, bus0.m_r, 0);
            return;
         end
      end
      for (int c = N + 1; c < N + 600; c++) begin
         @(negedge clk);
         vld = 1'b0;
         if (bus0.m_valid) begin
            fv = c;
            break;
         end
      end
   endtask

   int fv;

   initial begin
      vld = 1'b0; yr = '0; yi = '0; rst = 1'b1;
      repeat (2) @(negedge clk);
      vld = 1'b1;
      @(negedge clk);
      vld = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      chk("reset_valid", 0, bus0.m_valid, 0);
      chk("reset_idx", 0, bus0.m_idx, 0);
      chk("reset_re", 1, bus1.m_r, 0);
      chk("reset_last", 1, bus1.m_last, 0);
      chk("reset_busy", 0, busy0, 0);
      chk("reset_ovr", 0, ovr0, 0);
      chk_en = 1'b1;

      // natural and bit-reversed ramp readout
      vcnt0 = 0;
      send_frame(0, -1, -1, 1'b0, fv);
      chk("first_valid_cycle", 0, fv, 257);
      wait_idle();
      chk("ramp_valid_cycles", 0, vcnt0, 256);
      chk("ramp_last_re", 0, lastr0, 255);
      chk("brev_idx0", 1, rec1[0], 0);
      chk("brev_idx1", 1, rec1[1], 128);
      chk("brev_idx2", 1, rec1[2], 64);
      chk("brev_idx255", 1, rec1[255], 255);
      chk("ramp_ovr", 0, ovr0, 0);

      // back-to-back frames, second strobe on the last handshake
      vcnt0 = 0;
      send_frame(1, -1, -1, 1'b0, fv);
      send_frame(1, -1, -1, 1'b1, fv);
      wait_idle();
      chk("b2b_valid_cycles", 0, vcnt0, 512);
      chk("b2b_ovr", 0, ovr0, 0);

      // alternating backpressure
      rmode = 1;
      vcnt0 = 0;
      send_frame(0, -1, -1, 1'b0, fv);
      wait_idle();
      chk("bp_drain_len", 0, (vcnt0 >= 511 && vcnt0 <= 512), 1);
      rmode = 0;

      // spurious strobe during capture
      send_frame(0, 100, -1, 1'b0, fv);
      wait_idle();
      chk("ovr_sticky", 0, ovr0, 1);
      chk("ovr_sticky", 1, ovr1, 1);

      // reset in the middle of capture, then a clean frame
      send_frame(0, -1, 50, 1'b0, fv);
      vcnt0 = 0;
      send_frame(1, -1, -1, 1'b0, fv);
      wait_idle();
      chk("post_rst_valid_cycles", 0, vcnt0, 256);

      // random traffic: strobes, data, backpressure, occasional reset
      rmode = 2;
      for (int i = 0; i < 6000; i++) begin
         @(negedge clk);
         vld = ($urandom % 150) == 0;
         yr  = W'($urandom);
         yi  = W'($urandom);
         rst = ($urandom % 3000) == 0;
      end
      @(negedge clk);
      vld = 1'b0;
      rst = 1'b0;
      rmode = 0;
      wait_idle();
      @(negedge clk);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
